// File: rtl/i2c_pkg.sv
// Shared types and bus-level bit constants for the I2C register-file peripheral.
package i2c_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_PTR,
        ST_PTR_ACK,
        ST_WR,
        ST_WR_ACK,
        ST_RD,
        ST_RD_CACK
    } state_t;

    localparam logic ACK_BIT  = 1'b0;
    localparam logic NACK_BIT = 1'b1;
    localparam logic RW_WRITE = 1'b0;
    localparam logic RW_READ  = 1'b1;

endpackage

// File: rtl/i2c_line_sync.sv
// Synchronises SCL/SDA into the clk domain and flags SCL edges and START/STOP.
module i2c_line_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic scl_i,
    input  logic sda_i,
    output logic sda_o,
    output logic scl_rise_o,
    output logic scl_fall_o,
    output logic start_o,
    output logic stop_o
);

    logic [SYNC_STAGES-1:0] scl_sync_q;
    logic [SYNC_STAGES-1:0] sda_sync_q;
    logic                   scl_prev_q;
    logic                   sda_prev_q;
    logic                   scl_s;
    logic                   sda_s;

    // Reset to the idle-bus level so releasing rst never looks like an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
            scl_prev_q <= scl_s;
            sda_prev_q <= sda_s;
        end
    end

    assign scl_s      = scl_sync_q[SYNC_STAGES-1];
    assign sda_s      = sda_sync_q[SYNC_STAGES-1];
    assign sda_o      = sda_s;
    assign scl_rise_o = scl_s & ~scl_prev_q;
    assign scl_fall_o = ~scl_s & scl_prev_q;
    assign start_o    = scl_s & sda_prev_q & ~sda_s;
    assign stop_o     = scl_s & ~sda_prev_q & sda_s;

endmodule

// File: rtl/i2c_regfile_peripheral.sv
// I2C target exposing a pointer-addressed bank of 8-bit registers through a
// write strobe and a combinational read port.
module i2c_regfile_peripheral
    import i2c_pkg::*;
#(
    parameter logic [6:0] ADDRESS     = 7'h42,
    parameter int         NUM_REGS    = 16,
    parameter int         SYNC_STAGES = 2,
    localparam int        PW          = ($clog2(NUM_REGS) < 1) ? 1 : $clog2(NUM_REGS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          scl_i,
    input  logic          sda_i,
    output logic          sda_oe,
    output logic          wr_en,
    output logic [PW-1:0] wr_addr,
    output logic [7:0]    wr_data,
    output logic [PW-1:0] rd_addr,
    input  logic [7:0]    rd_data,
    output logic          busy,
    output state_t        dbg_state_o
);

    logic sda_s, scl_rise, scl_fall, start_det, stop_det;

    i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk        (clk),
        .rst        (rst),
        .scl_i      (scl_i),
        .sda_i      (sda_i),
        .sda_o      (sda_s),
        .scl_rise_o (scl_rise),
        .scl_fall_o (scl_fall),
        .start_o    (start_det),
        .stop_o     (stop_det)
    );

    state_t        state_q, state_d;
    logic [2:0]    cnt_q, cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic [PW-1:0] ptr_q, ptr_d;
    logic          sda_oe_q, sda_oe_d;
    logic          busy_q, busy_d;
    logic          wr_en_q, wr_en_d;
    logic [PW-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]    wr_data_q, wr_data_d;

    logic [7:0]    byte_in;
    logic          last_bit;
    logic          addr_match;
    logic          ptr_ok;
    logic [PW-1:0] ptr_inc;

    assign byte_in    = {shift_q[6:0], sda_s};
    assign last_bit   = scl_rise && (cnt_q == 3'd7);
    assign addr_match = (byte_in[7:1] == ADDRESS);
    assign ptr_ok     = ({1'b0, byte_in} < 9'(NUM_REGS));
    assign ptr_inc    = (ptr_q == PW'(NUM_REGS - 1)) ? '0 : ptr_q + PW'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            shift_q   <= '0;
            ptr_q     <= '0;
            sda_oe_q  <= 1'b0;
            busy_q    <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shift_q   <= shift_d;
            ptr_q     <= ptr_d;
            sda_oe_q  <= sda_oe_d;
            busy_q    <= busy_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    // In the ACK states sda_oe_q doubles as the phase: the first fall asserts, the second releases.
    always_comb begin
        state_d = state_q;
        if (start_det) begin
            state_d = ST_ADDR;
        end else if (stop_det) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_ADDR:     if (last_bit) state_d = addr_match ? ST_ADDR_ACK : ST_IDLE;
                ST_ADDR_ACK: if (scl_fall && sda_oe_q)
                                 state_d = (shift_q[0] == RW_READ) ? ST_RD : ST_PTR;
                ST_PTR:      if (last_bit) state_d = ptr_ok ? ST_PTR_ACK : ST_IDLE;
                ST_PTR_ACK:  if (scl_fall && sda_oe_q) state_d = ST_WR;
                ST_WR:       if (last_bit) state_d = ST_WR_ACK;
                ST_WR_ACK:   if (scl_fall && sda_oe_q) state_d = ST_WR;
                ST_RD:       if (scl_fall && cnt_q == 3'd7) state_d = ST_RD_CACK;
                ST_RD_CACK: begin
                    if (scl_rise && sda_s == NACK_BIT) state_d = ST_IDLE;
                    else if (scl_fall)                 state_d = ST_RD;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        ptr_d     = ptr_q;
        sda_oe_d  = sda_oe_q;
        busy_d    = busy_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        if (start_det || stop_det) begin
            cnt_d    = '0;
            sda_oe_d = 1'b0;
        end else begin
            case (state_q)
                ST_ADDR, ST_PTR, ST_WR: begin
                    if (scl_rise) begin
                        shift_d = byte_in;
                        cnt_d   = cnt_q + 3'd1;
                    end
                    if (last_bit && state_q == ST_ADDR && addr_match) busy_d = 1'b1;
                    if (last_bit && state_q == ST_PTR && ptr_ok) ptr_d = byte_in[PW-1:0];
                    if (last_bit && state_q == ST_WR) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = ptr_q;
                        wr_data_d = byte_in;
                        ptr_d     = ptr_inc;
                    end
                end
                ST_ADDR_ACK, ST_PTR_ACK, ST_WR_ACK: begin
                    if (scl_fall) begin
                        sda_oe_d = ~sda_oe_q;
                        cnt_d    = '0;
                        if (sda_oe_q && state_q == ST_ADDR_ACK && shift_q[0] == RW_READ) begin
                            shift_d  = rd_data;
                            sda_oe_d = ~rd_data[7];
                        end
                    end
                end
                ST_RD: begin
                    if (scl_fall) begin
                        if (cnt_q == 3'd7) begin
                            sda_oe_d = 1'b0;
                        end else begin
                            cnt_d    = cnt_q + 3'd1;
                            shift_d  = {shift_q[6:0], 1'b0};
                            sda_oe_d = ~shift_q[6];
                        end
                    end
                end
                ST_RD_CACK: begin
                    if (scl_rise && sda_s == ACK_BIT) begin
                        ptr_d = ptr_inc;
                    end else if (scl_fall) begin
                        shift_d  = rd_data;
                        sda_oe_d = ~rd_data[7];
                        cnt_d    = '0;
                    end
                end
                default: ;
            endcase
        end
        if (state_d == ST_IDLE) busy_d = 1'b0;
    end

    assign sda_oe      = sda_oe_q;
    assign busy        = busy_q;
    assign wr_en       = wr_en_q;
    assign wr_addr     = wr_addr_q;
    assign wr_data     = wr_data_q;
    assign rd_addr     = ptr_q;
    assign dbg_state_o = state_q;

endmodule
